// File: rtl/gshare_branch_predictor_pkg.sv
// Fetch-unit types shared by the gshare direction predictor and its
// prediction-select stage: table geometry, array entry layouts, the 2-bit
// counter encodings and the BranchPredict record handed to fetch.
// No ports (package).
package gshare_branch_predictor_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int PHT_INDEX_WIDTH = 10;
  // GHR_WIDTH and BTB_INDEX_WIDTH must not exceed PHT_INDEX_WIDTH.
  localparam int GHR_WIDTH       = 10;
  localparam int BTB_INDEX_WIDTH = 6;
  // The two instruction-alignment bits are not part of the tag.
  localparam int BTB_TAG_WIDTH   = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

  typedef logic [ADDR_WIDTH-1:0]      Addr;
  typedef logic [PHT_INDEX_WIDTH-1:0] PHTIndex;
  typedef logic [GHR_WIDTH-1:0]       GlobalBranchHistory;
  typedef logic [BTB_INDEX_WIDTH-1:0] BtbIndex;
  typedef logic [BTB_TAG_WIDTH-1:0]   BtbTag;
  typedef logic [1:0]                 PhtCounter;

  localparam PhtCounter PHT_STRONG_NOT_TAKEN = 2'd0;
  localparam PhtCounter PHT_WEAK_NOT_TAKEN   = 2'd1;
  localparam PhtCounter PHT_WEAK_TAKEN       = 2'd2;
  localparam PhtCounter PHT_STRONG_TAKEN     = 2'd3;

  typedef struct packed {
    logic  valid;
    BtbTag tag;
    Addr   target;
  } BtbEntry;

  typedef struct packed {
    logic               isNextPcPredicted;
    Addr                predictedNextPC;
    logic               isBranchTakenPredicted;
    PHTIndex            phtIndex;
    GlobalBranchHistory ghr;
  } BranchPredict;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } predictor_state_e;

  // Saturating 2-bit counter training step.
  function automatic PhtCounter pht_counter_next(PhtCounter c, logic taken);
    if (taken) begin
      return (c == PHT_STRONG_TAKEN) ? c : c + PhtCounter'(1);
    end
    return (c == PHT_STRONG_NOT_TAKEN) ? c : c - PhtCounter'(1);
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_predict_select.sv
// Combinational prediction select: turns the PHT counter and BTB entry read
// for the fetch PC into a BranchPredict record.
// Ports:
//   i_pc        fetch PC (fall-through is i_pc + 4)
//   i_is_branch predecode conditional-branch flag
//   i_counter   PHT counter read at i_pht_index
//   i_btb_entry BTB entry read at the fetch PC's BTB index
//   i_tag       BTB tag of the fetch PC
//   i_pht_index PHT index used, passed through for training
//   i_ghr       GHR before this branch, passed through for recovery
//   o_predict   resulting prediction record
module predict_select
  import gshare_branch_predictor_pkg::*;
(
  input  Addr                i_pc,
  input  logic               i_is_branch,
  input  PhtCounter          i_counter,
  input  BtbEntry            i_btb_entry,
  input  BtbTag              i_tag,
  input  PHTIndex            i_pht_index,
  input  GlobalBranchHistory i_ghr,
  output BranchPredict       o_predict
);

  logic w_taken;
  logic w_btb_hit;

  assign w_taken   = i_counter[1];
  assign w_btb_hit = i_btb_entry.valid && (i_btb_entry.tag == i_tag);

  always_comb begin
    o_predict          = '0;
    o_predict.phtIndex = i_pht_index;
    o_predict.ghr      = i_ghr;
    if (i_is_branch) begin
      if (!w_taken) begin
        o_predict.isNextPcPredicted = 1'b1;
        o_predict.predictedNextPC   = i_pc + Addr'(4);
      end else begin
        o_predict.isBranchTakenPredicted = 1'b1;
        // Taken without a known target: fetch cannot redirect yet.
        if (w_btb_hit) begin
          o_predict.isNextPcPredicted = 1'b1;
          o_predict.predictedNextPC   = i_btb_entry.target;
        end
      end
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor with a direct-mapped BTB and a speculative GHR.
// Looks up in the fetch cycle, presents a registered BranchPredict one cycle
// later, trains from execute-stage resolution and restores the GHR on a
// mispredict. The PHT and BTB carry no reset; an init sweep after reset
// writes every PHT entry to weakly not-taken and invalidates every BTB entry.
// Ports:
//   clk, rstN           clock, asynchronous active-low reset
//   lookupValid/Pc/IsBranch, stall   fetch-side request and hold
//   ready               low during the init sweep
//   predictValid, branchPredict      registered prediction
//   update*             execute-stage resolution and mispredict recovery
//
// state | meaning
// INIT  | sweeping arrays to their initial values; lookups/updates ignored
// RUN   | normal operation; left only through reset
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
(
  input  logic               clk,
  input  logic               rstN,
  input  logic               lookupValid,
  input  Addr                lookupPc,
  input  logic               lookupIsBranch,
  input  logic               stall,
  output logic               ready,
  output logic               predictValid,
  output BranchPredict       branchPredict,
  input  logic               updateValid,
  input  Addr                updatePc,
  input  PHTIndex            updatePhtIndex,
  input  GlobalBranchHistory updateGhr,
  input  logic               updateTaken,
  input  Addr                updateTarget,
  input  logic               updateMispredict
);

  localparam int PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_WIDTH;

  predictor_state_e   r_state;
  predictor_state_e   w_state_next;
  PHTIndex            r_init_idx;
  GlobalBranchHistory r_ghr;
  logic               r_predict_valid;
  BranchPredict       r_branch_predict;

  PhtCounter r_pht [PHT_ENTRIES];
  BtbEntry   r_btb [BTB_ENTRIES];

  logic         w_accept;
  logic         w_train;
  logic         w_recover;
  PHTIndex      w_lookup_pht_idx;
  BtbIndex      w_lookup_btb_idx;
  BtbTag        w_lookup_tag;
  BtbIndex      w_update_btb_idx;
  BtbEntry      w_update_entry;
  PhtCounter    w_pht_trained;
  BtbIndex      w_init_btb_idx;
  logic         w_init_in_btb;
  BranchPredict w_predict;
  logic         w_unused_update_bits;

  assign ready     = (r_state == ST_RUN);
  assign w_accept  = ready && lookupValid && !stall;
  assign w_train   = ready && updateValid;
  assign w_recover = w_train && updateMispredict;

  assign w_lookup_pht_idx = lookupPc[PHT_INDEX_WIDTH+1:2] ^ PHTIndex'(r_ghr);
  assign w_lookup_btb_idx = lookupPc[BTB_INDEX_WIDTH+1:2];
  assign w_lookup_tag     = lookupPc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];

  assign w_update_btb_idx      = updatePc[BTB_INDEX_WIDTH+1:2];
  assign w_update_entry.valid  = 1'b1;
  assign w_update_entry.tag    = updatePc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
  assign w_update_entry.target = updateTarget;
  assign w_pht_trained         = pht_counter_next(r_pht[updatePhtIndex], updateTaken);

  // The BTB is smaller than the PHT; only the low part of the sweep touches it.
  assign w_init_btb_idx = r_init_idx[BTB_INDEX_WIDTH-1:0];
  assign w_init_in_btb  = ((r_init_idx >> BTB_INDEX_WIDTH) == '0);

  assign w_unused_update_bits = ^{updatePc[1:0], updateGhr[GHR_WIDTH-1]};

  predict_select u_predict_select (
    .i_pc        (lookupPc),
    .i_is_branch (lookupIsBranch),
    .i_counter   (r_pht[w_lookup_pht_idx]),
    .i_btb_entry (r_btb[w_lookup_btb_idx]),
    .i_tag       (w_lookup_tag),
    .i_pht_index (w_lookup_pht_idx),
    .i_ghr       (r_ghr),
    .o_predict   (w_predict)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: if (r_init_idx == '1) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_init_idx       <= '0;
      r_ghr            <= '0;
      r_predict_valid  <= 1'b0;
      r_branch_predict <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_init_idx <= r_init_idx + PHTIndex'(1);
      end

      // Recovery wins over a same-cycle speculative shift.
      if (w_recover) begin
        r_ghr <= {updateGhr[GHR_WIDTH-2:0], updateTaken};
      end else if (w_accept && lookupIsBranch) begin
        r_ghr <= {r_ghr[GHR_WIDTH-2:0], w_predict.isBranchTakenPredicted};
      end

      // A mispredict squashes the next output even while fetch is stalled.
      if (w_recover) begin
        r_predict_valid <= 1'b0;
      end else if (!stall) begin
        r_predict_valid <= w_accept;
        if (w_accept) begin
          r_branch_predict <= w_predict;
        end
      end
    end
  end

  // Lookup reads above see these arrays before this edge's write: no bypass.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_pht[r_init_idx] <= PHT_WEAK_NOT_TAKEN;
      if (w_init_in_btb) begin
        r_btb[w_init_btb_idx] <= '0;
      end
    end else if (w_train) begin
      r_pht[updatePhtIndex] <= w_pht_trained;
      if (updateTaken) begin
        r_btb[w_update_btb_idx] <= w_update_entry;
      end
    end
  end

  assign predictValid  = r_predict_valid;
  assign branchPredict = r_branch_predict;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;
  import gshare_branch_predictor_pkg::*;

  localparam int PHT_N  = 1 << PHT_INDEX_WIDTH;
  localparam int BTB_N  = 1 << BTB_INDEX_WIDTH;
  localparam int INIT_CYCLES = PHT_N;

  logic               clk;
  logic               rstN;
  logic               lookupValid;
  Addr                lookupPc;
  logic               lookupIsBranch;
  logic               stall;
  logic               ready;
  logic               predictValid;
  BranchPredict       branchPredict;
  logic               updateValid;
  Addr                updatePc;
  PHTIndex            updatePhtIndex;
  GlobalBranchHistory updateGhr;
  logic               updateTaken;
  Addr                updateTarget;
  logic               updateMispredict;

  gshare_branch_predictor dut (
    .clk              (clk),
    .rstN             (rstN),
    .lookupValid      (lookupValid),
    .lookupPc         (lookupPc),
    .lookupIsBranch   (lookupIsBranch),
    .stall            (stall),
    .ready            (ready),
    .predictValid     (predictValid),
    .branchPredict    (branchPredict),
    .updateValid      (updateValid),
    .updatePc         (updatePc),
    .updatePhtIndex   (updatePhtIndex),
    .updateGhr        (updateGhr),
    .updateTaken      (updateTaken),
    .updateTarget     (updateTarget),
    .updateMispredict (updateMispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain arrays holding the architectural table contents.
  int                 m_pht [PHT_N];
  bit                 m_btb_v [BTB_N];
  Addr                m_btb_pc [BTB_N];
  Addr                m_btb_tgt [BTB_N];
  int unsigned        m_ghr;
  bit                 m_out_valid;
  BranchPredict       m_out;
  BranchPredict       exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    for (int i = 0; i < BTB_N; i++) begin
      m_btb_v[i]   = 1'b0;
      m_btb_pc[i]  = '0;
      m_btb_tgt[i] = '0;
    end
    m_ghr       = 0;
    m_out_valid = 1'b0;
    m_out       = '0;
  endtask

  function automatic int unsigned btb_slot(input Addr pc);
    return (pc / 4) % BTB_N;
  endfunction

  function automatic BranchPredict model_predict(input Addr pc, input bit br);
    BranchPredict e;
    int unsigned  idx;
    int unsigned  s;
    e   = '0;
    idx = ((pc / 4) % PHT_N) ^ m_ghr;
    s   = btb_slot(pc);
    e.phtIndex = PHTIndex'(idx);
    e.ghr      = GlobalBranchHistory'(m_ghr);
    if (br) begin
      if (m_pht[idx] < 2) begin
        e.isNextPcPredicted = 1'b1;
        e.predictedNextPC   = pc + 4;
      end else begin
        e.isBranchTakenPredicted = 1'b1;
        // Hit when the stored branch lives at the same tag (PC above index bits).
        if (m_btb_v[s] && ((m_btb_pc[s] / (BTB_N * 4)) == (pc / (BTB_N * 4)))) begin
          e.isNextPcPredicted = 1'b1;
          e.predictedNextPC   = m_btb_tgt[s];
        end
      end
    end
    return e;
  endfunction

  task automatic idle_inputs();
    lookupValid      = 1'b0;
    lookupPc         = '0;
    lookupIsBranch   = 1'b0;
    stall            = 1'b0;
    updateValid      = 1'b0;
    updatePc         = '0;
    updatePhtIndex   = '0;
    updateGhr        = '0;
    updateTaken      = 1'b0;
    updateTarget     = '0;
    updateMispredict = 1'b0;
  endtask

  // One RUN-mode cycle: drive inputs, advance the model, wait for the edge.
  task automatic step(input bit lv, input Addr pc, input bit br, input bit st,
                      input bit uv, input Addr upc, input int unsigned uidx,
                      input int unsigned ughr, input bit ut, input Addr utgt, input bit um);
    BranchPredict e;
    bit acc;
    bit rec;
    lookupValid      = lv;
    lookupPc         = pc;
    lookupIsBranch   = br;
    stall            = st;
    updateValid      = uv;
    updatePc         = upc;
    updatePhtIndex   = PHTIndex'(uidx);
    updateGhr        = GlobalBranchHistory'(ughr);
    updateTaken      = ut;
    updateTarget     = utgt;
    updateMispredict = um;
    acc = lv && !st;
    rec = uv && um;
    e = model_predict(pc, br);
    if (rec) m_out_valid = 1'b0;
    else if (!st) begin
      m_out_valid = acc;
      if (acc) m_out = e;
    end
    if (m_out_valid) exp_q.push_back(m_out);
    if (rec) m_ghr = ((ughr * 2) + int'(ut)) % (1 << GHR_WIDTH);
    else if (acc && br) m_ghr = ((m_ghr * 2) + int'(e.isBranchTakenPredicted)) % (1 << GHR_WIDTH);
    if (uv) begin
      if (ut) begin
        if (m_pht[uidx] < 3) m_pht[uidx]++;
        m_btb_v[btb_slot(upc)]   = 1'b1;
        m_btb_pc[btb_slot(upc)]  = upc;
        m_btb_tgt[btb_slot(upc)] = utgt;
      end else if (m_pht[uidx] > 0) begin
        m_pht[uidx]--;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic lookup(input Addr pc, input bit br);
    step(1'b1, pc, br, 1'b0, 1'b0, '0, 0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic train(input Addr upc, input int unsigned uidx, input bit ut, input Addr utgt);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, upc, uidx, 0, ut, utgt, 1'b0);
  endtask

  task automatic nop();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!ready && cycles < 3 * INIT_CYCLES) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  function automatic Addr rand_pc();
    return Addr'(($urandom_range(0, 3) * 256) + ($urandom_range(0, 15) * 4));
  endfunction

  // Scoreboard monitor: every presented prediction must match the queue head.
  initial begin
    BranchPredict e;
    forever begin
      @(negedge clk);
      if (rstN && predictValid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL predict_unexpected: got predictValid=1 with no prediction outstanding");
        end else begin
          e = exp_q.pop_front();
          if (branchPredict !== e) begin
            n_fail++;
            $display("FAIL predict_compare: got nextOk=%0b next=%h taken=%0b idx=%h ghr=%h, expected nextOk=%0b next=%h taken=%0b idx=%h ghr=%h",
                     branchPredict.isNextPcPredicted, branchPredict.predictedNextPC,
                     branchPredict.isBranchTakenPredicted, branchPredict.phtIndex, branchPredict.ghr,
                     e.isNextPcPredicted, e.predictedNextPC, e.isBranchTakenPredicted, e.phtIndex, e.ghr);
          end
        end
      end
    end
  end

  initial begin
    int   cycles;
    Addr  pc;
    Addr  upc;
    int unsigned idx;
    bit   uv;
    bit   um;
    bit   ut;

    idle_inputs();
    rstN = 1'b1;
    #3 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_predict_valid", 64'(predictValid), 64'd0);
    check("reset_branch_predict", 64'(branchPredict), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);

    // Release, let the sweep run part way with junk traffic, then restart it.
    rstN = 1'b1;
    lookupValid = 1'b1; lookupIsBranch = 1'b1; lookupPc = 32'h100;
    updateValid = 1'b1; updateMispredict = 1'b1; updateTaken = 1'b1;
    updatePhtIndex = PHTIndex'(32'h40); updatePc = 32'h100; updateTarget = 32'h500;
    updateGhr = GlobalBranchHistory'(32'h3ff);
    repeat (100) @(posedge clk);
    #1;
    check("midsweep_ready_low", 64'(ready), 64'd0);
    check("midsweep_predict_valid", 64'(predictValid), 64'd0);
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    wait_ready(cycles);
    idle_inputs();
    check("init_sweep_cycles", 64'(cycles), 64'(INIT_CYCLES));
    model_reset();

    // First lookup after init: weakly not-taken everywhere.
    lookup(32'h100, 1'b1);
    // Two taken trainings with GHR still zero.
    train(32'h100, 32'h40, 1'b1, 32'h200);
    train(32'h100, 32'h40, 1'b1, 32'h200);
    lookup(32'h100, 1'b1);
    // BTB miss: counter 2 at the lookup index of 0x3C0, its BTB slot untouched.
    idx = ((32'h3C0 / 4) % PHT_N) ^ m_ghr;
    train(32'h1000, idx, 1'b1, 32'h2000);
    lookup(32'h3C0, 1'b1);
    // Saturation: four taken then one not-taken leaves the counter at 2.
    idx = ((32'h100 / 4) % PHT_N) ^ m_ghr;
    repeat (4) train(32'h100, idx, 1'b1, 32'h200);
    train(32'h100, idx, 1'b0, 32'h0);
    lookup(32'h100, 1'b1);
    // Recovery priority: GHR 0101, then a mispredict alongside a branch lookup.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h8000, 32'h3ff, 32'h2, 1'b1, 32'h9000, 1'b1);
    step(1'b1, 32'h140, 1'b1, 1'b0, 1'b1, 32'h8000, 32'h3ff, 32'h3, 1'b1, 32'h9000, 1'b1);
    check("recovery_squash", 64'(predictValid), 64'd0);
    lookup(32'h144, 1'b0);
    // Stall for three cycles with lookups asserted: output and GHR hold.
    lookup(32'h100, 1'b1);
    repeat (3) step(1'b1, 32'h180, 1'b1, 1'b1, 1'b0, '0, 0, 0, 1'b0, '0, 1'b0);
    lookup(32'h184, 1'b1);
    // Back-to-back branch lookups.
    lookup(32'h100, 1'b1);
    lookup(32'h100, 1'b1);
    lookup(32'h3C0, 1'b1);

    for (int i = 0; i < 2500; i++) begin
      pc  = rand_pc();
      upc = rand_pc();
      uv  = ($urandom_range(0, 2) == 0);
      um  = ($urandom_range(0, 5) == 0);
      ut  = ($urandom_range(0, 2) != 0);
      idx = ((upc / 4) % PHT_N) ^ $urandom_range(0, 3);
      step(($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), uv, upc, idx, $urandom_range(0, PHT_N - 1),
           ut, Addr'($urandom_range(0, 32'hffff) * 4), um);
    end
    nop(); nop(); nop();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-run while a prediction is being presented.
    lookup(32'h100, 1'b1);
    rstN = 1'b0;
    #1;
    check("midrun_reset_valid", 64'(predictValid), 64'd0);
    check("midrun_reset_bp", 64'(branchPredict), 64'd0);
    check("midrun_reset_ready", 64'(ready), 64'd0);
    exp_q.delete();
    idle_inputs();
    @(posedge clk); #1;
    rstN = 1'b1;
    wait_ready(cycles);
    check("reinit_sweep_cycles", 64'(cycles), 64'(INIT_CYCLES));
    model_reset();
    lookup(32'h100, 1'b1);
    lookup(32'h3C0, 1'b1);
    nop(); nop();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
